// File: rtl/vx_join_commit_pkg.sv
// Shared types for the join-commit stage: join response from the split/join unit
// and the PC/tmask redirect handed to the warp scheduler.
package vx_join_commit_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  typedef logic [NW_WIDTH-1:0] wid_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_dvg;
    logic                   is_else;
    wid_t                   wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
  } join_rsp_t;

  typedef struct packed {
    wid_t                   wid;
    logic [XLEN-1:0]        pc;
    logic [NUM_THREADS-1:0] tmask;
  } warp_redir_t;

endpackage

// File: rtl/vx_join_commit_fifo.sv
// Small synchronous FIFO with async active-high reset; head is presented from
// storage so the consumer sees a stable entry until it pops.
module vx_join_commit_fifo #(
  parameter int DATAW = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [DATAW-1:0] i_data,
  output logic [DATAW-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATAW-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/vx_join_commit.sv
// Join-commit stage: applies split/join results to per-warp masks and stall flags,
// and queues else-path PC redirects for the warp scheduler.
module vx_join_commit
  import vx_join_commit_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int THREAD_CNT  = NUM_THREADS,
  parameter int REDIR_DEPTH = NUM_WARPS
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_stall_set_valid,
  input  logic [NW_WIDTH-1:0]             i_stall_set_wid,
  input  logic                            i_split_valid,
  input  logic                            i_split_is_dvg,
  input  logic [NW_WIDTH-1:0]             i_split_wid,
  input  logic [THREAD_CNT-1:0]           i_split_then_tmask,
  input  logic                            i_join_valid,
  input  logic                            i_join_is_dvg,
  input  logic                            i_join_is_else,
  input  logic [NW_WIDTH-1:0]             i_join_wid,
  input  logic [THREAD_CNT-1:0]           i_join_tmask,
  input  logic [XLEN-1:0]                 i_join_pc,
  output logic [NUM_WARPS*THREAD_CNT-1:0] o_warp_tmask,
  output logic [NUM_WARPS-1:0]            o_warp_stalled,
  output logic                            o_redir_valid,
  input  logic                            i_redir_ready,
  output logic [NW_WIDTH-1:0]             o_redir_wid,
  output logic [XLEN-1:0]                 o_redir_pc,
  output logic [THREAD_CNT-1:0]           o_redir_tmask
);

  join_rsp_t             w_join;
  warp_redir_t           w_push_data;
  warp_redir_t           w_head;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_join_clear;
  logic [THREAD_CNT-1:0] r_tmask [NUM_WARPS];
  logic [THREAD_CNT-1:0] w_tmask_n [NUM_WARPS];
  logic [NUM_WARPS-1:0]  r_stalled;
  logic [NUM_WARPS-1:0]  w_stalled_n;

  assign w_join = '{valid: i_join_valid, is_dvg: i_join_is_dvg, is_else: i_join_is_else,
                    wid: i_join_wid, tmask: i_join_tmask, pc: i_join_pc};

  assign w_push       = w_join.valid & w_join.is_dvg & w_join.is_else;
  assign w_join_clear = w_join.valid & ~(w_join.is_dvg & w_join.is_else);
  assign w_pop        = ~w_empty & i_redir_ready;
  assign w_push_data  = '{wid: w_join.wid, pc: w_join.pc, tmask: w_join.tmask};

  vx_join_commit_fifo #(
    .DATAW ($bits(warp_redir_t)),
    .DEPTH (REDIR_DEPTH)
  ) u_redir_q (
    .i_clk   (i_clk),
    .i_reset (~i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_data),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Join is applied last so it overrides a same-warp split; clears override stall_set.
  always_comb begin
    w_tmask_n   = r_tmask;
    w_stalled_n = r_stalled;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (i_split_valid && i_split_is_dvg && i_split_wid == wid_t'(w))
        w_tmask_n[w] = i_split_then_tmask;
      if (i_stall_set_valid && i_stall_set_wid == wid_t'(w))
        w_stalled_n[w] = 1'b1;
      if (w_pop && w_head.wid == wid_t'(w))
        w_stalled_n[w] = 1'b0;
      if (w_join.valid && w_join.wid == wid_t'(w)) begin
        if (w_join.is_dvg) w_tmask_n[w] = w_join.tmask;
        if (w_join_clear)  w_stalled_n[w] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++)
        r_tmask[w] <= (w == 0) ? THREAD_CNT'(1) : '0;
      r_stalled <= '0;
    end else begin
      r_tmask   <= w_tmask_n;
      r_stalled <= w_stalled_n;
    end
  end

  always_comb begin
    o_warp_tmask = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      o_warp_tmask[w*THREAD_CNT +: THREAD_CNT] = r_tmask[w];
  end

  assign o_warp_stalled = r_stalled;
  assign o_redir_valid  = ~w_empty;
  assign o_redir_wid    = w_head.wid;
  assign o_redir_pc     = w_head.pc;
  assign o_redir_tmask  = w_head.tmask;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      assert (!(w_push && w_full && !w_pop))
        else $warning("core%0d: redirect queue full, warp %0d redirect dropped", CORE_ID, w_join.wid);
      assert (!(w_join.valid && i_split_valid && i_split_is_dvg && i_split_wid == w_join.wid))
        else $warning("core%0d: join and split on warp %0d in one cycle, join applied", CORE_ID, w_join.wid);
      assert (!(w_join_clear && i_stall_set_valid && i_stall_set_wid == w_join.wid))
        else $warning("core%0d: stall_set and join clear on warp %0d in one cycle, clear applied", CORE_ID, w_join.wid);
    end
  end
`endif

endmodule

// File: tb/tb_vx_join_commit.sv
// Randomized scoreboard bench for vx_join_commit against a per-warp array/queue model.
module tb_vx_join_commit;
  import vx_join_commit_pkg::*;

  localparam int NW    = NUM_WARPS;
  localparam int NT    = NUM_THREADS;
  localparam int DEPTH = NUM_WARPS;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_stall_set_valid;
  logic [NW_WIDTH-1:0] i_stall_set_wid;
  logic                i_split_valid;
  logic                i_split_is_dvg;
  logic [NW_WIDTH-1:0] i_split_wid;
  logic [NT-1:0]       i_split_then_tmask;
  logic                i_join_valid;
  logic                i_join_is_dvg;
  logic                i_join_is_else;
  logic [NW_WIDTH-1:0] i_join_wid;
  logic [NT-1:0]       i_join_tmask;
  logic [XLEN-1:0]     i_join_pc;
  logic [NW*NT-1:0]    o_warp_tmask;
  logic [NW-1:0]       o_warp_stalled;
  logic                o_redir_valid;
  logic                i_redir_ready;
  logic [NW_WIDTH-1:0] o_redir_wid;
  logic [XLEN-1:0]     o_redir_pc;
  logic [NT-1:0]       o_redir_tmask;

  vx_join_commit #(.CORE_ID(0), .THREAD_CNT(NT), .REDIR_DEPTH(DEPTH)) dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_stall_set_valid  (i_stall_set_valid),
    .i_stall_set_wid    (i_stall_set_wid),
    .i_split_valid      (i_split_valid),
    .i_split_is_dvg     (i_split_is_dvg),
    .i_split_wid        (i_split_wid),
    .i_split_then_tmask (i_split_then_tmask),
    .i_join_valid       (i_join_valid),
    .i_join_is_dvg      (i_join_is_dvg),
    .i_join_is_else     (i_join_is_else),
    .i_join_wid         (i_join_wid),
    .i_join_tmask       (i_join_tmask),
    .i_join_pc          (i_join_pc),
    .o_warp_tmask       (o_warp_tmask),
    .o_warp_stalled     (o_warp_stalled),
    .o_redir_valid      (o_redir_valid),
    .i_redir_ready      (i_redir_ready),
    .o_redir_wid        (o_redir_wid),
    .o_redir_pc         (o_redir_pc),
    .o_redir_tmask      (o_redir_tmask)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    int          wid;
    logic [31:0] pc;
    logic [NT-1:0] tmask;
  } redir_t;

  redir_t        exp_q[$];
  logic [NT-1:0] m_tmask [NW];
  bit            m_stalled [NW];
  bit            pend_pop;
  int            pend_wid;
  int            checks = 0;
  int            errors = 0;
  logic [NW*NT-1:0] mon_tm;
  logic [NW-1:0]    mon_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void reset_model();
    for (int w = 0; w < NW; w++) begin
      m_tmask[w]   = (w == 0) ? NT'(1) : '0;
      m_stalled[w] = 1'b0;
    end
    exp_q.delete();
    pend_pop = 1'b0;
  endfunction

  function automatic bit warp_queued(input int w);
    foreach (exp_q[i]) if (exp_q[i].wid == w) return 1'b1;
    return 1'b0;
  endfunction

  // Reference model: rules applied in priority order, later rules win.
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (i_split_valid && i_split_is_dvg) m_tmask[i_split_wid] = i_split_then_tmask;
      if (i_stall_set_valid) m_stalled[i_stall_set_wid] = 1'b1;
      if (pend_pop) m_stalled[pend_wid] = 1'b0;
      if (i_join_valid) begin
        if (i_join_is_dvg) m_tmask[i_join_wid] = i_join_tmask;
        if (!(i_join_is_dvg && i_join_is_else)) m_stalled[i_join_wid] = 1'b0;
        else if (exp_q.size() < DEPTH)
          exp_q.push_back('{wid: int'(i_join_wid), pc: i_join_pc, tmask: i_join_tmask});
      end
    end
    pend_pop = 1'b0;
  end

  // Monitor: compares state and queue head every negedge; retires on handshake.
  always @(negedge i_clk) begin
    for (int w = 0; w < NW; w++) begin
      mon_tm[w*NT +: NT] = m_tmask[w];
      mon_st[w]          = m_stalled[w];
    end
    check("warp_tmask", 64'(o_warp_tmask), 64'(mon_tm));
    check("warp_stalled", 64'(o_warp_stalled), 64'(mon_st));
    if (exp_q.size() > 0) begin
      check("redir_valid", 64'(o_redir_valid), 64'd1);
      check("redir_wid", 64'(o_redir_wid), 64'(exp_q[0].wid));
      check("redir_pc", 64'(o_redir_pc), 64'(exp_q[0].pc));
      check("redir_tmask", 64'(o_redir_tmask), 64'(exp_q[0].tmask));
      if (i_redir_ready && i_rst_n) begin
        pend_pop = 1'b1;
        pend_wid = exp_q[0].wid;
        void'(exp_q.pop_front());
      end
    end else begin
      check("redir_valid_idle", 64'(o_redir_valid), 64'd0);
    end
  end

  task automatic clear_events();
    i_stall_set_valid = 1'b0;
    i_split_valid     = 1'b0;
    i_split_is_dvg    = 1'b0;
    i_join_valid      = 1'b0;
    i_join_is_dvg     = 1'b0;
    i_join_is_else    = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick_clear();
    tick();
    clear_events();
  endtask

  task automatic set_stall(input int w);
    i_stall_set_valid = 1'b1;
    i_stall_set_wid   = NW_WIDTH'(w);
  endtask

  task automatic set_split(input int w, input bit dvg, input logic [NT-1:0] m);
    i_split_valid      = 1'b1;
    i_split_is_dvg     = dvg;
    i_split_wid        = NW_WIDTH'(w);
    i_split_then_tmask = m;
  endtask

  task automatic set_join(input int w, input bit dvg, input bit els,
                          input logic [NT-1:0] m, input logic [31:0] pc);
    i_join_valid   = 1'b1;
    i_join_is_dvg  = dvg;
    i_join_is_else = els;
    i_join_wid     = NW_WIDTH'(w);
    i_join_tmask   = m;
    i_join_pc      = pc;
  endtask

  initial begin
    int p[NW];
    reset_model();
    clear_events();
    i_stall_set_wid = '0; i_split_wid = '0; i_split_then_tmask = '0;
    i_join_wid = '0; i_join_tmask = '0; i_join_pc = '0;
    i_redir_ready = 1'b0;
    i_rst_n = 1'b0;
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    #1;
    check("rst_tmask", 64'(o_warp_tmask), 64'h0001);
    check("rst_stalled", 64'(o_warp_stalled), 64'h0);
    check("rst_redir_valid", 64'(o_redir_valid), 64'h0);
    tick();

    set_split(1, 1'b1, 4'b0011); tick_clear();
    check("split_w1", 64'(o_warp_tmask[7:4]), 64'b0011);
    set_join(1, 1'b1, 1'b0, 4'b1111, 32'h0); tick_clear();
    check("reconv_w1", 64'(o_warp_tmask[7:4]), 64'b1111);
    check("reconv_no_redir", 64'(o_redir_valid), 64'd0);

    set_stall(2); tick_clear();
    check("stall_w2", 64'(o_warp_stalled[2]), 64'd1);
    set_join(2, 1'b1, 1'b1, 4'b1100, 32'h8000_0040); tick_clear();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 64'(o_redir_valid), 64'd1);
      check("hold_wid", 64'(o_redir_wid), 64'd2);
      check("hold_pc", 64'(o_redir_pc), 64'h8000_0040);
      check("hold_tmask", 64'(o_redir_tmask), 64'b1100);
      check("hold_stalled", 64'(o_warp_stalled[2]), 64'd1);
      tick();
    end
    i_redir_ready = 1'b1; tick();
    check("accept_unstall", 64'(o_warp_stalled[2]), 64'd0);
    check("accept_empty", 64'(o_redir_valid), 64'd0);
    i_redir_ready = 1'b0;

    for (int w = 0; w < NW; w++) begin set_stall(w); tick_clear(); end
    for (int w = 0; w < NW; w++) begin
      set_join(w, 1'b1, 1'b1, NT'($urandom), 32'h1000 + 32'(w * 16));
      tick_clear();
    end
    check("all_stalled", 64'(o_warp_stalled), 64'hF);
    i_redir_ready = 1'b1;
    repeat (NW + 2) tick();
    i_redir_ready = 1'b0;
    check("all_released", 64'(o_warp_stalled), 64'h0);

    set_stall(3); set_join(3, 1'b0, 1'b0, 4'b0000, 32'h0); tick_clear();
    check("clear_wins", 64'(o_warp_stalled[3]), 64'd0);
    set_split(1, 1'b1, 4'b0101); set_join(2, 1'b1, 1'b0, 4'b1010, 32'h0); tick_clear();
    check("indep_split_w1", 64'(o_warp_tmask[7:4]), 64'b0101);
    check("indep_join_w2", 64'(o_warp_tmask[11:8]), 64'b1010);

    // Random traffic; each event type on a distinct warp, one redirect per warp.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NW; i++) p[i] = i;
      for (int i = NW - 1; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(i, 0));
        t = p[i]; p[i] = p[j]; p[j] = t;
      end
      i_redir_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(2, 0) == 0) set_split(p[1], 1'(($urandom)), NT'($urandom));
      if ($urandom_range(2, 0) == 0) set_stall(p[2]);
      if ($urandom_range(1, 0) == 0) begin
        bit dvg, els;
        dvg = 1'($urandom);
        els = dvg && !warp_queued(p[0]) && ($urandom_range(1, 0) == 0);
        set_join(p[0], dvg, els, NT'($urandom), $urandom);
      end
      tick_clear();
    end
    i_redir_ready = 1'b1;
    repeat (NW + 2) tick();
    i_redir_ready = 1'b0;

    set_join(0, 1'b1, 1'b1, 4'b0110, 32'h2000); tick_clear();
    set_join(1, 1'b1, 1'b1, 4'b1001, 32'h3000); tick_clear();
    check("pre_reset_valid", 64'(o_redir_valid), 64'd1);
    #2;
    i_rst_n = 1'b0;
    reset_model();
    #1;
    check("midrst_valid", 64'(o_redir_valid), 64'd0);
    check("midrst_tmask", 64'(o_warp_tmask), 64'h0001);
    check("midrst_stalled", 64'(o_warp_stalled), 64'h0);
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_valid", 64'(o_redir_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
